// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock/tick divider.
// Each channel divides clk by its own runtime divisor and produces a
// registered square output and a one-cycle end-of-period tick. A new
// divisor is held pending until the current period completes, or applied
// right away while the channel is disabled, so the outputs never glitch.
module clk_div_multi #(
  parameter int CHANNELS             = 2,
  parameter int CNT_W                = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_we,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pend
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DEFAULT_DIV);

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] divAct_q, divAct_d;
    logic [CNT_W-1:0] divPend_q, divPend_d;
    logic             pend_q, pend_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] divRaw, divNorm, divLast, divHalf;
    logic             boundary;

    // A written divisor of zero would mean "never wrap", so it is stored as one.
    assign divRaw  = div_in[g*CNT_W +: CNT_W];
    assign divNorm = (divRaw == '0) ? ONE : divRaw;

    // Period arithmetic; divAct_q is never zero so D-1 cannot underflow.
    assign divLast  = divAct_q - ONE;
    assign divHalf  = divAct_q >> 1;
    assign boundary = (cnt_q == divLast);

    // Next-state: counting, output shaping and boundary-aligned divisor updates.
    always_comb begin
      cnt_d     = cnt_q;
      divAct_d  = divAct_q;
      divPend_d = divPend_q;
      pend_d    = pend_q;
      clkOut_d  = clkOut_q;
      tick_d    = 1'b0;
      if (!en[g]) begin
        cnt_d    = '0;
        clkOut_d = 1'b0;
        if (div_we[g]) begin
          divAct_d = divNorm;
          pend_d   = 1'b0;
        end else if (pend_q) begin
          divAct_d = divPend_q;
          pend_d   = 1'b0;
        end
      end else begin
        tick_d   = boundary;
        clkOut_d = (divAct_q > ONE) ? (cnt_q < divHalf) : ~clkOut_q;
        if (boundary) begin
          cnt_d = '0;
          if (div_we[g]) begin
            divAct_d = divNorm;
            pend_d   = 1'b0;
          end else if (pend_q) begin
            divAct_d = divPend_q;
            pend_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (div_we[g]) begin
            divPend_d = divNorm;
            pend_d    = 1'b1;
          end
        end
      end
    end

    // Channel state registers; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        divAct_q  <= DIV_INIT;
        divPend_q <= DIV_INIT;
        pend_q    <= 1'b0;
        clkOut_q  <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        divAct_q  <= divAct_d;
        divPend_q <= divPend_d;
        pend_q    <= pend_d;
        clkOut_q  <= clkOut_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[g] = clkOut_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed bench for clk_div_multi, two 8-bit channels
// with a reset divisor of 4.
module tb_clk_div_multi;

  localparam int CHANNELS = 2;
  localparam int CNT_W    = 8;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*CNT_W-1:0] div_in;
  logic [CHANNELS-1:0]       div_we;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pend;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] en;
    logic [1:0] we;
    logic [7:0] div0;
    logic [7:0] div1;
    logic [1:0] co;
    logic [1:0] tk;
    logic [1:0] pd;
  } vec_t;

  vec_t vecs[18];

  clk_div_multi #(
    .CHANNELS(CHANNELS),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .div_in(div_in),
    .div_we(div_we),
    .clk_out(clk_out),
    .tick(tick),
    .pend(pend)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] expCo,
                             input logic [1:0] expTk, input logic [1:0] expPd);
    checks++;
    if (clk_out !== expCo || tick !== expTk || pend !== expPd) begin
      errors++;
      $display("[TB] FAIL %s: got clk_out=%b tick=%b pend=%b, expected clk_out=%b tick=%b pend=%b",
               name, clk_out, tick, pend, expCo, expTk, expPd);
    end
  endtask

  // Expected {clk_out, tick} after the k-th enabled edge (k starts at 1) for divisor d>=2.
  function automatic logic [1:0] phaseOut(input int k, input int d);
    int ph;
    ph = (k - 1) % d;
    return {(ph < d / 2) ? 1'b1 : 1'b0, (ph == d - 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic doReset();
    rst_n  = 1'b0;
    en     = 2'b00;
    div_we = 2'b00;
    div_in = '0;
    step();
    rst_n = 1'b1;
    checkOutput("reset_state", 2'b00, 2'b00, 2'b00);
  endtask

  task automatic applyStimulus();
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] expCo;
    logic [1:0] expTk;
    int k0;
    int k1;

    // Default divisor 4 on both channels, then a mid-period write of 5 on channel 0.
    vecs[0]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[1]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[2]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00};
    vecs[4]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[5]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[6]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00};
    vecs[8]  = '{2'b11, 2'b01, 8'd5, 8'd0, 2'b11, 2'b00, 2'b01};
    vecs[9]  = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b01};
    vecs[10] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b01};
    vecs[11] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00};
    vecs[12] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[13] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};
    vecs[14] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
    vecs[15] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b10, 2'b00};
    vecs[16] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b10, 2'b01, 2'b00};
    vecs[17] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b11, 2'b00, 2'b00};

    rst_n  = 1'b0;
    en     = 2'b00;
    div_we = 2'b00;
    div_in = '0;
    #12;
    checkOutput("reset_async", 2'b00, 2'b00, 2'b00);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      en     = vecs[i].en;
      div_we = vecs[i].we;
      div_in = {vecs[i].div1, vecs[i].div0};
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].co, vecs[i].tk, vecs[i].pd);
    end
    div_we = 2'b00;

    // Divisor 0 is treated as 1: toggle every clock, tick constantly high.
    doReset();
    div_in = '0;
    div_we = 2'b11;
    step();
    div_we = 2'b00;
    checkOutput("div0_write_disabled", 2'b00, 2'b00, 2'b00);
    en = 2'b01;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput($sformatf("div1_cyc%0d", i), {1'b0, (i % 2 == 0) ? 1'b1 : 1'b0}, 2'b01, 2'b00);
    end

    // Independent periods 2 and 3; channel 1 is paused without disturbing channel 0.
    doReset();
    div_in = {8'd3, 8'd2};
    div_we = 2'b11;
    step();
    div_we = 2'b00;
    en = 2'b11;
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 9)  en[1] = 1'b0;
      if (c == 12) en[1] = 1'b1;
      step();
      k0++;
      p0 = phaseOut(k0, 2);
      if (en[1]) begin
        k1++;
        p1 = phaseOut(k1, 3);
      end else begin
        k1 = 0;
        p1 = 2'b00;
      end
      expCo = {p1[1], p0[1]};
      expTk = {p1[0], p0[0]};
      checkOutput($sformatf("dual_cyc%0d", c), expCo, expTk, 2'b00);
      if (c == 5) begin
        checks++;
        if (tick !== 2'b11) begin
          errors++;
          $display("[TB] FAIL tick_coincide: got tick=%b, expected 11", tick);
        end
      end
    end

    // Disabled write of 7 applies without waiting; enabling gives high 3, low 4.
    doReset();
    div_in = {8'd0, 8'd7};
    div_we = 2'b01;
    step();
    div_we = 2'b00;
    step();
    checkOutput("dis_write_pend", 2'b00, 2'b00, 2'b00);
    en = 2'b01;
    for (int c = 1; c <= 14; c++) begin
      step();
      p0 = phaseOut(c, 7);
      checkOutput($sformatf("div7_cyc%0d", c), {1'b0, p0[1]}, {1'b0, p0[0]}, 2'b00);
    end

    // Async reset mid-period with a pending write: the write is discarded.
    doReset();
    en = 2'b01;
    step();
    step();
    div_in = {8'd0, 8'd9};
    div_we = 2'b01;
    step();
    div_we = 2'b00;
    checkOutput("pend_before_reset", 2'b00, 2'b00, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_period", 2'b00, 2'b00, 2'b00);
    #3;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      p0 = phaseOut(c, 4);
      checkOutput($sformatf("post_reset_cyc%0d", c), {1'b0, p0[1]}, {1'b0, p0[0]}, 2'b00);
    end
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock/tick divider; successor to the fixed-divisor single-output divider.
- Each channel divides clk by a runtime-writable divisor and produces a square output and a one-cycle tick.
- Divisor changes take effect only at period boundaries, so outputs never glitch.
- Feeds peripheral timers, UART baud ticks and display refresh in the CPU top level.

Parameters:
CHANNELS, 2, number of independent divider channels
CNT_W, 32, counter/divisor width in bits
DEFAULT_DIV, 50_000_000, divisor loaded into every channel at reset; must be >=1 and <2^CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  CHANNELS  per-channel enable, level
div_in  in  CHANNELS*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W]
div_we  in  CHANNELS  per-channel divisor write strobe, one cycle
clk_out  out  CHANNELS  per-channel divided square output, registered
tick  out  CHANNELS  per-channel one-cycle pulse at end of each period, registered
pend  out  CHANNELS  per-channel flag: written divisor not yet applied

Behaviour:
- Reset (async, rst_n=0): all channels cnt=0, div_act=DEFAULT_DIV, pend=0, clk_out=0, tick=0.
- Divisor normalisation: a written value of 0 is stored as 1.
- Per-channel state: cnt, div_act, div_pend, pend. Channels are fully independent.
- Write (div_we[i]=1): div_pend<=normalised div_in slice; pend<=1. A later write before apply overwrites div_pend (last write wins).
- Enabled (en[i]=1), D=div_act:
  - cnt counts 0..D-1 and wraps to 0.
  - Boundary = cnt==D-1.
  - clk_out next = (D>=2) ? (cnt < D/2, floor) : ~clk_out. D=1 gives a period-2 toggle.
  - tick next = 1 exactly when the boundary is reached, else 0. D=1 gives tick high every cycle.
  - Duty for odd D: high floor(D/2) cycles, low ceil(D/2).
- Apply at boundary: if pend=1 (or div_we in the same cycle), div_act<=new value, cnt<=0, pend<=0. A write coinciding with the boundary is applied at that boundary, bypassing div_pend.
- Disabled (en[i]=0):
  - cnt<=0, clk_out<=0, tick<=0.
  - Any pending divisor is applied immediately (next edge); pend<=0.
- Enable rising: counting starts from cnt=0. clk_out goes high on the first edge after en is sampled high (when D>=2).
- Output latency: one clk from counter state to clk_out/tick (registered, no combinational paths from inputs to outputs).
- Reset mid-operation: immediate async clear to reset values; any pending write is lost.
- Arithmetic: D-1 and D/2 are computed at CNT_W bits. D>=1 is guaranteed by normalisation, so no underflow.

Test Plan:
1. Reset with DEFAULT_DIV=4, en=1 -> clk_out pattern 1,1,0,0 repeating; tick high one cycle every 4 clks, coinciding with the last low cycle.
2. Channel 0: write div=5 mid-period while D=4, en=1 -> pend=1 until the current 4-cycle period ends; then period 5 with clk_out high 2, low 3; pend=0.
3. Write div=0 -> treated as 1; clk_out toggles every clk; tick constantly 1.
4. Channel 0 D=2, channel 1 D=3, both enabled -> independent periods 2 and 3; tick coincidence every 6 clks. Toggling en[1] does not disturb channel 0.
5. en=0 with write div=7 -> pend clears next clk, outputs stay 0. Set en=1 -> clk_out high 3 cycles, low 4.
6. Assert rst_n=0 asynchronously mid-period with pend=1 -> outputs 0 immediately. After release: div_act=DEFAULT_DIV, pend=0, counting restarts from 0.
